mem_trace_buffer: RTL and testbench

Synthesizable successor to the bench-only RAM write tracker. Sits beside the CPU/RAM interface in cpu_garage. It captures qualified data-memory accesses into an on-chip trace FIFO, with these generalisations:
- parametrised widths and depth
- optional read capture
- address-window filtering
- arm/trigger/stop control
- selectable stop-on-full or wrap-around overflow policy
Entries drain through a valid/ready port, so traces are available on silicon and in any simulator.

---
 rtl/mem_trace_buffer.sv | 179 +++++++++++++++++
 tb/tb_mem_trace_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_trace_buffer.sv
// Captures qualified CPU data-memory accesses into a first-word-fall-through trace FIFO drained over valid/ready.
// Supports arm/trigger/stop control, address-window filtering, optional read capture and stop-on-full or wrap overflow.
module mem_trace_buffer #(
   parameter int ADDR_W        = 15,
   parameter int DATA_W        = 16,
   parameter int TS_W          = 32,
   parameter int DEPTH         = 16,
   parameter int CAPTURE_READS = 0,
   parameter int WRAP_MODE     = 0
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     we,
   input  logic                     re,
   input  logic [ADDR_W-1:0]        ram_address,
   input  logic [DATA_W-1:0]        cpu_out_m,
   input  logic [DATA_W-1:0]        ram_rdata,
   input  logic                     arm,
   input  logic                     stop,
   input  logic                     trig_en,
   input  logic [ADDR_W-1:0]        trig_addr,
   input  logic [ADDR_W-1:0]        win_lo,
   input  logic [ADDR_W-1:0]        win_hi,
   output logic                     trc_valid,
   input  logic                     trc_ready,
   output logic                     trc_rw,
   output logic [TS_W-1:0]          trc_time,
   output logic [ADDR_W-1:0]        trc_addr,
   output logic [DATA_W-1:0]        trc_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [15:0]              drop_count,
   output logic [1:0]               state
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   typedef struct packed {
      logic              rw;
      logic [TS_W-1:0]   ts;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            mem_q [DEPTH];
   entry_t            new_entry;
   entry_t            head;
   state_t            state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       drop_q, drop_d;
   logic [TS_W-1:0]   ts_q;
   logic              access, qual, push, flush, pop, full, wr_en;

   // A simultaneous write and read strobe is recorded as a single write.
   always_comb begin
      access    = we | ((CAPTURE_READS != 0) & re & ~we);
      qual      = access && (ram_address >= win_lo) && (ram_address <= win_hi);
      new_entry = '{rw: we, ts: ts_q, addr: ram_address, data: (we ? cpu_out_m : ram_rdata)};
      full      = (count_q == CNT_W'(DEPTH));
   end

   always_comb begin
      state_d    = state_q;
      push       = 1'b0;
      flush      = 1'b0;
      wr_en      = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (arm) begin
               state_d = S_ARMED;
               flush   = 1'b1;
            end
         end
         S_ARMED: begin
            if (stop) begin
               state_d = S_DONE;
            end else if (!trig_en) begin
               state_d = S_CAPTURE;
            end else if (access && (ram_address == trig_addr)) begin
               // The trigger access itself is recorded if it lies in the window.
               state_d = S_CAPTURE;
               push    = qual;
            end
         end
         S_CAPTURE: begin
            if (stop) state_d = S_DONE;
            else      push    = qual;
         end
         default: state_d = S_IDLE;
      endcase

      pop = (count_q != '0) & trc_ready & ~flush;

      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         drop_d     = '0;
      end else begin
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push) begin
            if (!full || pop) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
               overflow_d = 1'b1;
               if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
               if (WRAP_MODE != 0) begin
                  // Overwrite the oldest entry; occupancy stays at DEPTH.
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
                  rd_ptr_d = rd_ptr_q + PTR_W'(1);
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         if (wr_en && !pop && !full)  count_d = count_q + CNT_W'(1);
         else if (pop && !wr_en)      count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
         ts_q       <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
         ts_q       <= ts_q + TS_W'(1);
      end
   end

   // Storage needs no reset: unoccupied slots are masked by trc_valid.
   always_ff @(posedge Clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= new_entry;
   end

   always_comb begin
      head       = mem_q[rd_ptr_q];
      trc_valid  = (count_q != '0);
      trc_rw     = trc_valid & head.rw;
      trc_time   = trc_valid ? head.ts   : '0;
      trc_addr   = trc_valid ? head.addr : '0;
      trc_data   = trc_valid ? head.data : '0;
      count      = count_q;
      overflow   = overflow_q;
      drop_count = drop_q;
      state      = state_q;
   end

endmodule

// File: tb/tb_mem_trace_buffer.sv
// Scoreboarded bench for mem_trace_buffer: one DUT with read capture (DEPTH 16), two with DEPTH 4 (stop and wrap).
module tb_mem_trace_buffer;

   typedef struct packed {
      logic        rw;
      logic [31:0] ts;
      logic [14:0] addr;
      logic [15:0] data;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        we = 1'b0, re = 1'b0, arm = 1'b0, stop = 1'b0, trig_en = 1'b0;
   logic [14:0] ram_address = '0, trig_addr = '0, win_lo = '0, win_hi = 15'h7FFF;
   logic [15:0] cpu_out_m = '0, ram_rdata = '0;
   logic        rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;
   logic [31:0] tb_ts = '0;

   logic        vld_a, rw_a, ovf_a, vld_b, rw_b, ovf_b, vld_c, rw_c, ovf_c;
   logic [31:0] time_a, time_b, time_c;
   logic [14:0] addr_a, addr_b, addr_c;
   logic [15:0] data_a, data_b, data_c, drop_a, drop_b, drop_c;
   logic [4:0]  cnt_a;
   logic [2:0]  cnt_b, cnt_c;
   logic [1:0]  st_a, st_b, st_c;

   int   checks = 0;
   int   errors = 0;
   exp_t qa[$], qb[$], qc[$];
   exp_t e;

   mem_trace_buffer #(.CAPTURE_READS(1)) dut_a (
      .Clk(Clk), .Reset(Reset), .we(we), .re(re), .ram_address(ram_address), .cpu_out_m(cpu_out_m),
      .ram_rdata(ram_rdata), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_addr(trig_addr),
      .win_lo(win_lo), .win_hi(win_hi), .trc_valid(vld_a), .trc_ready(rdy_a), .trc_rw(rw_a),
      .trc_time(time_a), .trc_addr(addr_a), .trc_data(data_a), .count(cnt_a), .overflow(ovf_a),
      .drop_count(drop_a), .state(st_a));

   mem_trace_buffer #(.DEPTH(4), .WRAP_MODE(0)) dut_b (
      .Clk(Clk), .Reset(Reset), .we(we), .re(re), .ram_address(ram_address), .cpu_out_m(cpu_out_m),
      .ram_rdata(ram_rdata), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_addr(trig_addr),
      .win_lo(win_lo), .win_hi(win_hi), .trc_valid(vld_b), .trc_ready(rdy_b), .trc_rw(rw_b),
      .trc_time(time_b), .trc_addr(addr_b), .trc_data(data_b), .count(cnt_b), .overflow(ovf_b),
      .drop_count(drop_b), .state(st_b));

   mem_trace_buffer #(.DEPTH(4), .WRAP_MODE(1)) dut_c (
      .Clk(Clk), .Reset(Reset), .we(we), .re(re), .ram_address(ram_address), .cpu_out_m(cpu_out_m),
      .ram_rdata(ram_rdata), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_addr(trig_addr),
      .win_lo(win_lo), .win_hi(win_hi), .trc_valid(vld_c), .trc_ready(rdy_c), .trc_rw(rw_c),
      .trc_time(time_c), .trc_addr(addr_c), .trc_data(data_c), .count(cnt_c), .overflow(ovf_c),
      .drop_count(drop_c), .state(st_c));

   always #5 Clk = ~Clk;

   // Reference cycle counter: value seen between edges equals the timestamp of that cycle.
   always @(posedge Clk) tb_ts <= Reset ? 32'd0 : tb_ts + 32'd1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic rw, input logic [31:0] ts, input logic [14:0] a, input logic [15:0] d);
      mk = '{rw: rw, ts: ts, addr: a, data: d};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wr(input logic [14:0] a, input logic [15:0] d);
      we = 1'b1; ram_address = a; cpu_out_m = d;
      tick();
      we = 1'b0;
   endtask

   task automatic arm_and_go();
      arm = 1'b1; tick(); arm = 1'b0; tick(); tick();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (4) tick();
      checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", st_a); end
      checks++; if (cnt_a !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", cnt_a); end
      checks++; if ({vld_a, rw_a, time_a, addr_a, data_a} !== '0) begin errors++; $display("FAIL reset_trc: got v=%0b t=%0h a=%0h d=%0h required all 0", vld_a, time_a, addr_a, data_a); end
      checks++; if ({ovf_a, drop_a} !== '0) begin errors++; $display("FAIL reset_overflow: got ovf=%0b drop=%0d required 0/0", ovf_a, drop_a); end
      Reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [31:0] t;
      arm_and_go();
      checks++; if (st_a !== 2'd2) begin errors++; $display("FAIL basic_state: got %0d required 2", st_a); end
      t = tb_ts;
      wr(15'h0010, 16'h1234);
      checks++; if ({vld_a, rw_a, addr_a, data_a, time_a} !== {1'b1, 1'b1, 15'h0010, 16'h1234, t}) begin errors++;
         $display("FAIL basic_entry: got v=%0b rw=%0b a=%0h d=%0h t=%0d required 1/1/10/1234/%0d", vld_a, rw_a, addr_a, data_a, time_a, t); end
      checks++; if (cnt_a !== 5'd1) begin errors++; $display("FAIL basic_count: got %0d required 1", cnt_a); end
      tick();
      checks++; if ({vld_a, addr_a} !== {1'b1, 15'h0010}) begin errors++; $display("FAIL basic_stall: got v=%0b a=%0h required 1/10", vld_a, addr_a); end
      rdy_a = 1'b1; tick(); rdy_a = 1'b0;
      checks++; if ({vld_a, cnt_a} !== {1'b0, 5'd0}) begin errors++; $display("FAIL basic_pop: got v=%0b cnt=%0d required 0/0", vld_a, cnt_a); end
   endtask

   task automatic test_window();
      win_lo = 15'h4000; win_hi = 15'h5FFF;
      wr(15'h0005, 16'h1111);
      qa.push_back(mk(1'b1, tb_ts, 15'h4000, 16'h2222));
      wr(15'h4000, 16'h2222);
      wr(15'h6000, 16'h3333);
      qa.push_back(mk(1'b0, tb_ts, 15'h4001, 16'hBEEF));
      re = 1'b1; ram_address = 15'h4001; ram_rdata = 16'hBEEF; tick(); re = 1'b0;
      qa.push_back(mk(1'b1, tb_ts, 15'h4002, 16'h5555));
      re = 1'b1; ram_rdata = 16'h6666; wr(15'h4002, 16'h5555); re = 1'b0;
      win_lo = 15'h5000; win_hi = 15'h4000;
      wr(15'h4800, 16'h7777);
      win_lo = 15'h0000; win_hi = 15'h7FFF;
      checks++; if (cnt_a !== 5'd3) begin errors++; $display("FAIL window_count: got %0d required 3", cnt_a); end
      for (int i = 0; i < 20 && qa.size() > 0; i++) begin
         if (vld_a) begin
            e = qa.pop_front();
            checks++; if ({rw_a, time_a, addr_a, data_a} !== e) begin errors++;
               $display("FAIL window_entry: got rw=%0b t=%0d a=%0h d=%0h required rw=%0b t=%0d a=%0h d=%0h", rw_a, time_a, addr_a, data_a, e.rw, e.ts, e.addr, e.data); end
            rdy_a = 1'b1; tick(); rdy_a = 1'b0;
         end else tick();
      end
      checks++; if (qa.size() != 0 || vld_a !== 1'b0) begin errors++; $display("FAIL window_drain: got %0d left v=%0b required 0/0", qa.size(), vld_a); end
   endtask

   task automatic test_trigger();
      stop = 1'b1; tick(); stop = 1'b0;
      checks++; if (st_a !== 2'd3) begin errors++; $display("FAIL trig_stop: got %0d required 3", st_a); end
      trig_en = 1'b1; trig_addr = 15'h0100;
      arm = 1'b1; tick(); arm = 1'b0;
      wr(15'h0050, 16'hAAAA);
      checks++; if (st_a !== 2'd1) begin errors++; $display("FAIL trig_armed: got %0d required 1", st_a); end
      qa.push_back(mk(1'b1, tb_ts, 15'h0100, 16'hBBBB));
      wr(15'h0100, 16'hBBBB);
      checks++; if (st_a !== 2'd2) begin errors++; $display("FAIL trig_capture: got %0d required 2", st_a); end
      qa.push_back(mk(1'b1, tb_ts, 15'h0101, 16'hCCCC));
      wr(15'h0101, 16'hCCCC);
      trig_en = 1'b0;
      checks++; if (cnt_a !== 5'd2) begin errors++; $display("FAIL trig_count: got %0d required 2", cnt_a); end
      for (int i = 0; i < 20 && qa.size() > 0; i++) begin
         if (vld_a) begin
            e = qa.pop_front();
            checks++; if ({rw_a, time_a, addr_a, data_a} !== e) begin errors++;
               $display("FAIL trig_entry: got t=%0d a=%0h d=%0h required t=%0d a=%0h d=%0h", time_a, addr_a, data_a, e.ts, e.addr, e.data); end
            rdy_a = 1'b1; tick(); rdy_a = 1'b0;
         end else tick();
      end
      checks++; if (qa.size() != 0) begin errors++; $display("FAIL trig_drain: got %0d left required 0", qa.size()); end
   endtask

   task automatic test_overflow();
      Reset = 1'b1; repeat (2) tick(); Reset = 1'b0;
      arm_and_go();
      for (int i = 1; i <= 6; i++) begin
         qc.push_back(mk(1'b1, tb_ts, 15'(i), 16'(16'hA0 + i)));
         wr(15'(i), 16'(16'hA0 + i));
      end
      while (qc.size() > 4) void'(qc.pop_front());
      checks++; if ({cnt_b, ovf_b, drop_b, st_b} !== {3'd4, 1'b1, 16'd1, 2'd3}) begin errors++;
         $display("FAIL stop_full: got cnt=%0d ovf=%0b drop=%0d st=%0d required 4/1/1/3", cnt_b, ovf_b, drop_b, st_b); end
      checks++; if ({addr_b, data_b} !== {15'd1, 16'hA1}) begin errors++; $display("FAIL stop_head: got a=%0h d=%0h required 1/a1", addr_b, data_b); end
      checks++; if ({cnt_c, ovf_c, drop_c, st_c} !== {3'd4, 1'b1, 16'd2, 2'd2}) begin errors++;
         $display("FAIL wrap_full: got cnt=%0d ovf=%0b drop=%0d st=%0d required 4/1/2/2", cnt_c, ovf_c, drop_c, st_c); end
      for (int i = 0; i < 20 && qc.size() > 0; i++) begin
         if (vld_c) begin
            e = qc.pop_front();
            checks++; if ({rw_c, time_c, addr_c, data_c} !== e) begin errors++;
               $display("FAIL wrap_order: got t=%0d a=%0h d=%0h required t=%0d a=%0h d=%0h", time_c, addr_c, data_c, e.ts, e.addr, e.data); end
            rdy_c = 1'b1; tick(); rdy_c = 1'b0;
         end else tick();
      end
      checks++; if (qc.size() != 0) begin errors++; $display("FAIL wrap_drain: got %0d left required 0", qc.size()); end
      stop = 1'b1; wr(15'd7, 16'hA7); stop = 1'b0;
      checks++; if ({st_c, cnt_c} !== {2'd3, 3'd0}) begin errors++; $display("FAIL wrap_stop: got st=%0d cnt=%0d required 3/0", st_c, cnt_c); end
      arm = 1'b1; rdy_b = 1'b1; tick(); arm = 1'b0; rdy_b = 1'b0;
      checks++; if ({cnt_b, vld_b, ovf_b, drop_b, st_b} !== {3'd0, 1'b0, 1'b0, 16'd0, 2'd1}) begin errors++;
         $display("FAIL stop_rearm: got cnt=%0d v=%0b ovf=%0b drop=%0d st=%0d required 0/0/0/0/1", cnt_b, vld_b, ovf_b, drop_b, st_b); end
   endtask

   task automatic test_back_to_back();
      tick();
      checks++; if (st_b !== 2'd2) begin errors++; $display("FAIL b2b_state: got %0d required 2", st_b); end
      for (int i = 1; i <= 4; i++) begin
         qb.push_back(mk(1'b1, tb_ts, 15'(16 + i), 16'(16'hB0 + i)));
         wr(15'(16 + i), 16'(16'hB0 + i));
      end
      e = qb.pop_front();
      checks++; if ({cnt_b, rw_b, time_b, addr_b, data_b} !== {3'd4, e}) begin errors++;
         $display("FAIL b2b_head: got cnt=%0d a=%0h t=%0d required 4/%0h/%0d", cnt_b, addr_b, time_b, e.addr, e.ts); end
      qb.push_back(mk(1'b1, tb_ts, 15'd21, 16'hB5));
      rdy_b = 1'b1; wr(15'd21, 16'hB5); rdy_b = 1'b0;
      checks++; if ({cnt_b, ovf_b, drop_b} !== {3'd4, 1'b0, 16'd0}) begin errors++;
         $display("FAIL b2b_full_pushpop: got cnt=%0d ovf=%0b drop=%0d required 4/0/0", cnt_b, ovf_b, drop_b); end
      for (int i = 0; i < 20 && qb.size() > 0; i++) begin
         if (vld_b) begin
            e = qb.pop_front();
            checks++; if ({rw_b, time_b, addr_b, data_b} !== e) begin errors++;
               $display("FAIL b2b_order: got t=%0d a=%0h d=%0h required t=%0d a=%0h d=%0h", time_b, addr_b, data_b, e.ts, e.addr, e.data); end
            rdy_b = 1'b1; tick(); rdy_b = 1'b0;
         end else tick();
      end
      checks++; if (qb.size() != 0 || cnt_b !== 3'd0) begin errors++; $display("FAIL b2b_drain: got %0d left cnt=%0d required 0/0", qb.size(), cnt_b); end
      rdy_b = 1'b1; wr(15'd9, 16'h0099); rdy_b = 1'b0;
      checks++; if ({cnt_b, vld_b, addr_b, data_b} !== {3'd1, 1'b1, 15'd9, 16'h0099}) begin errors++;
         $display("FAIL empty_pushpop: got cnt=%0d v=%0b a=%0h d=%0h required 1/1/9/99", cnt_b, vld_b, addr_b, data_b); end
      wr(15'd10, 16'h00AA);
      Reset = 1'b1; tick(); Reset = 1'b0;
      checks++; if ({cnt_b, vld_b, rw_b, time_b, addr_b, data_b, ovf_b, drop_b, st_b} !== '0) begin errors++;
         $display("FAIL midreset_b: got cnt=%0d v=%0b t=%0d a=%0h st=%0d required all 0", cnt_b, vld_b, time_b, addr_b, st_b); end
      checks++; if ({cnt_a, vld_a, st_a, cnt_c, st_c} !== '0) begin errors++;
         $display("FAIL midreset_ac: got cnt_a=%0d st_a=%0d cnt_c=%0d st_c=%0d required all 0", cnt_a, st_a, cnt_c, st_c); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_window();
      test_trigger();
      test_overflow();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
